// File: rtl/aes_disp_pkg.sv
// Shared types and seven-segment helpers for the AES byte display sequencer.
package aes_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SHOW = 2'd2
  } disp_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes render blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/aes_byte_bcd.sv
// Iterative 8-bit binary to 3-digit BCD converter (double dabble, one bit per cycle).
// bcd carries the result of the iteration in progress, so it is final while done is high.
module aes_byte_bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  logic [7:0]  bin_reg;
  logic [11:0] bcd_reg;
  logic [2:0]  cnt_reg;
  logic        run_reg;
  logic [11:0] adj;
  logic [11:0] bcd_next;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                            : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign bcd_next = {adj[10:0], bin_reg[7]};
  assign bcd      = bcd_next;
  assign done     = run_reg && (cnt_reg == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_reg <= 8'd0;
      bcd_reg <= 12'd0;
      cnt_reg <= 3'd0;
      run_reg <= 1'b0;
    end else if (start) begin
      bin_reg <= bin;
      bcd_reg <= 12'd0;
      cnt_reg <= 3'd0;
      run_reg <= 1'b1;
    end else if (run_reg) begin
      bin_reg <= {bin_reg[6:0], 1'b0};
      bcd_reg <= bcd_next;
      cnt_reg <= cnt_reg + 3'd1;
      if (cnt_reg == 3'd7) run_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_byte_display_seq.sv
// Steps through the 16 bytes of an accepted block, showing each in decimal on three digits.
// Build macro: DISP_LOOP_EN makes the sequence repeat instead of returning to IDLE.
module aes_byte_display_seq
  import aes_disp_pkg::*;
#(
  parameter int DWELL = 50_000_000,
  parameter int DW    = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  input  logic [127:0] blk_data,
  output logic         blk_ready,
  output logic         busy,
  output logic [3:0]   byte_idx,
  output logic [6:0]   HEX2,
  output logic [6:0]   HEX1,
  output logic [6:0]   HEX0
);

  disp_state_t   state_reg, state_next;
  logic [127:0]  cap_reg;
  logic [3:0]    byte_idx_reg;
  logic [DW-1:0] dwell_reg;
  logic [6:0]    hex2_reg, hex1_reg, hex0_reg;

  logic          dwell_end;
  logic          last_byte;
  logic [3:0]    next_idx;
  logic [3:0]    next_pos;
  logic [7:0]    next_byte;
  logic          capture;
  logic          conv_start;
  logic [7:0]    conv_bin;
  logic          conv_done;
  logic [11:0]   conv_bcd;
  logic [6:0]    hex2_next, hex1_next, hex0_next;

  assign dwell_end = (dwell_reg == DW'(DWELL - 1));
  assign last_byte = (byte_idx_reg == 4'd15);
  assign next_idx  = byte_idx_reg + 4'd1;
  assign next_pos  = 4'd15 - next_idx;
  assign next_byte = cap_reg[{next_pos, 3'b000} +: 8];

`ifdef DISP_LOOP_EN
  assign blk_ready = (state_reg == IDLE) ||
                     ((state_reg == SHOW) && last_byte && dwell_end);
`else
  assign blk_ready = (state_reg == IDLE);
`endif

  assign busy     = (state_reg != IDLE);
  assign byte_idx = byte_idx_reg;
  assign HEX2     = hex2_reg;
  assign HEX1     = hex1_reg;
  assign HEX0     = hex0_reg;

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    conv_start = 1'b0;
    conv_bin   = next_byte;
    case (state_reg)
      IDLE: begin
        if (blk_valid && blk_ready) begin
          capture    = 1'b1;
          conv_start = 1'b1;
          conv_bin   = blk_data[127:120];
          state_next = CONV;
        end
      end
      CONV: begin
        if (conv_done) state_next = SHOW;
      end
      SHOW: begin
        if (dwell_end) begin
`ifdef DISP_LOOP_EN
          if (last_byte && blk_valid) begin
            capture  = 1'b1;
            conv_bin = blk_data[127:120];
          end
          conv_start = 1'b1;
          state_next = CONV;
`else
          if (last_byte) begin
            state_next = IDLE;
          end else begin
            conv_start = 1'b1;
            state_next = CONV;
          end
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Leading zeros blank; a zero between nonzero digits is still drawn.
  always_comb begin
    hex0_next = seg_decode(conv_bcd[3:0]);
    hex1_next = seg_decode(conv_bcd[7:4]);
    hex2_next = seg_decode(conv_bcd[11:8]);
    if (conv_bcd[11:8] == 4'd0) begin
      hex2_next = SEG_BLANK;
      if (conv_bcd[7:4] == 4'd0) hex1_next = SEG_BLANK;
    end
  end

  aes_byte_bcd u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_reg      <= 128'd0;
      byte_idx_reg <= 4'd0;
      dwell_reg    <= '0;
      hex2_reg     <= SEG_BLANK;
      hex1_reg     <= SEG_BLANK;
      hex0_reg     <= SEG_BLANK;
    end else begin
      if (capture) cap_reg <= blk_data;
      if (capture) byte_idx_reg <= 4'd0;
      else if (conv_start) byte_idx_reg <= next_idx;
      if (state_reg == CONV && conv_done) begin
        dwell_reg <= '0;
        hex2_reg  <= hex2_next;
        hex1_reg  <= hex1_next;
        hex0_reg  <= hex0_next;
      end else if (state_reg == SHOW) begin
        dwell_reg <= dwell_reg + DW'(1);
      end
    end
  end

endmodule
